// File: rtl/out_port_arbiter.sv
// Output-port arbiter: picks one FIFO whose head packet is addressed to this port
// (round-robin) and streams that packet's bytes out until the last one is popped.
module out_port_arbiter #(
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned PORT_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sw_en,
  input  logic [N_PORTS-1:0]           fifo_empty,
  input  logic [N_PORTS*W_WIDTH-1:0]   fifo_head,
  input  logic                         port_ready,
  output logic [N_PORTS-1:0]           rd_en,
  output logic [N_PORTS-1:0]           grant,
  output logic [W_WIDTH-1:0]           port_out,
  output logic                         port_valid
);

  localparam int unsigned CW = W_WIDTH + 1;
  localparam int unsigned IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state_q, state_d;
  logic [N_PORTS-1:0]   grant_d;
  logic [IW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [W_WIDTH-1:0]   len_q, len_d;
  logic [W_WIDTH-1:0]   out_d;
  logic                 valid_d;
  logic [N_PORTS-1:0]   active;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [W_WIDTH-1:0]   head_g;
  logic                 pop;
  logic                 last_pop;

  // A requester is active when its head byte addresses this port.
  always_comb begin
    active = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      active[i] = !fifo_empty[i] &&
                  (fifo_head[i*W_WIDTH +: W_WIDTH] == W_WIDTH'(PORT_ADDR));
    end
  end

  // Round-robin search starting just after the previous winner.
  always_comb begin
    logic [IW:0] sum;
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int k = 1; k <= int'(N_PORTS); k++) begin
      sum = {1'b0, last_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_PORTS)) sum = sum - (IW+1)'(N_PORTS);
      if (!pick_found && active[IW'(sum)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(sum);
      end
    end
  end

  // Head byte of the granted FIFO.
  always_comb begin
    head_g = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (grant[i]) head_g = fifo_head[i*W_WIDTH +: W_WIDTH];
    end
  end

  assign pop = (state_q == XFER) && port_ready && |(grant & ~fifo_empty);

  // On the length-byte pop, L is still on the FIFO head rather than in len_q.
  assign last_pop = (cnt_q == CW'(1)) ? (head_g == '0)
                                      : (cnt_q == (CW'(len_q) + CW'(1)));

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    last_d  = last_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    out_d   = port_out;
    valid_d = 1'b0;
    rd_en   = '0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (sw_en && pick_found) begin
          grant_d = N_PORTS'(1) << pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (pop) begin
          rd_en   = grant;
          out_d   = head_g;
          valid_d = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(1)) len_d = head_g;
          if (last_pop) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant      <= '0;
      last_q     <= IW'(N_PORTS - 1);
      cnt_q      <= '0;
      len_q      <= '0;
      port_out   <= '0;
      port_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      port_out   <= out_d;
      port_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: FIFOs are modelled as byte queues popped on rd_en.
module tb_out_port_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           sw_en;
  logic [N-1:0]   fifo_empty;
  logic [N*W-1:0] fifo_head;
  logic           port_ready;
  logic [N-1:0]   rd_en;
  logic [N-1:0]   grant;
  logic [W-1:0]   port_out;
  logic           port_valid;

  logic [7:0] fq [N][$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  out_port_arbiter #(.W_WIDTH(8), .N_PORTS(4), .PORT_ADDR(3)) dut (
    .clk(clk), .rst(rst), .sw_en(sw_en), .fifo_empty(fifo_empty),
    .fifo_head(fifo_head), .port_ready(port_ready), .rd_en(rd_en),
    .grant(grant), .port_out(port_out), .port_valid(port_valid)
  );

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]     = (fq[i].size() == 0);
      fifo_head[i*W +: W] = (fq[i].size() == 0) ? 8'h00 : fq[i][0];
    end
  endtask

  // One clock: rd_en sampled mid-cycle, FIFOs popped just after the edge.
  task automatic tick();
    logic [N-1:0] pops;
    @(negedge clk);
    pops = rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pops[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    refresh();
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_en = 1'b0; port_ready = 1'b1;
    refresh();
    tick(); tick();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (port_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", port_valid); end
    checks++; if (port_out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", port_out); end
    checks++; if (rd_en !== 4'b0000) begin failures++; $display("FAIL reset_rd_en got=%b exp=0000", rd_en); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] e [4];
    e = '{8'h03, 8'h02, 8'hA5, 8'h5A};
    fq[1].push_back(8'h03); fq[1].push_back(8'h02);
    fq[1].push_back(8'hA5); fq[1].push_back(8'h5A);
    refresh();
    sw_en = 1'b1; port_ready = 1'b1;
    tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", grant); end
    checks++; if (port_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", port_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({port_valid, port_out} !== {1'b1, e[k]}) begin
        failures++; $display("FAIL single_byte%0d got=%b/%h exp=1/%h", k, port_valid, port_out, e[k]);
      end
    end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", grant); end
    tick();
    checks++; if (port_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b exp=0", port_valid); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] order [4];
    logic [N-1:0] prev;
    int ng;
    int nbytes;
    ng = 0; nbytes = 0; prev = '0;
    for (int k = 0; k < 4; k++) order[k] = '0;
    rst = 1'b1; #1; rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      fq[0].push_back(8'h03); fq[0].push_back(8'h00);
      fq[2].push_back(8'h03); fq[2].push_back(8'h00);
    end
    refresh();
    for (int t = 0; t < 20; t++) begin
      tick();
      if (port_valid) nbytes++;
      if (grant !== 4'b0000 && prev === 4'b0000) begin
        if (ng < 4) order[ng] = grant;
        ng++;
      end
      prev = grant;
    end
    checks++; if (ng != 4) begin failures++; $display("FAIL fair_grant_count got=%0d exp=4", ng); end
    checks++; if (order[0] !== 4'b0001) begin failures++; $display("FAIL fair_order0 got=%b exp=0001", order[0]); end
    checks++; if (order[1] !== 4'b0100) begin failures++; $display("FAIL fair_order1 got=%b exp=0100", order[1]); end
    checks++; if (order[2] !== 4'b0001) begin failures++; $display("FAIL fair_order2 got=%b exp=0001", order[2]); end
    checks++; if (order[3] !== 4'b0100) begin failures++; $display("FAIL fair_order3 got=%b exp=0100", order[3]); end
    checks++; if (nbytes != 8) begin failures++; $display("FAIL fair_bytes got=%0d exp=8", nbytes); end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [5];
    e = '{8'h03, 8'h03, 8'h11, 8'h22, 8'h33};
    foreach (e[k]) fq[1].push_back(e[k]);
    refresh();
    tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL bp_grant got=%b exp=0010", grant); end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        port_ready = 1'b0; #1;
        checks++; if (rd_en !== 4'b0000) begin failures++; $display("FAIL bp_rd_en got=%b exp=0000", rd_en); end
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++;
          if ({port_valid, port_out, grant} !== {1'b0, 8'h03, 4'b0010}) begin
            failures++; $display("FAIL bp_stall%0d got=%b/%h/%b exp=0/03/0010", s, port_valid, port_out, grant);
          end
        end
        port_ready = 1'b1;
      end
      tick();
      checks++;
      if ({port_valid, port_out} !== {1'b1, e[k]}) begin
        failures++; $display("FAIL bp_byte%0d got=%b/%h exp=1/%h", k, port_valid, port_out, e[k]);
      end
    end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL bp_release got=%b exp=0000", grant); end
    checks++; if (fq[1].size() != 0) begin failures++; $display("FAIL bp_left got=%0d exp=0", fq[1].size()); end
  endtask

  task automatic test_underflow();
    logic [7:0] e [5];
    int nv;
    e = '{8'h03, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    nv = 0;
    for (int k = 0; k < 3; k++) fq[2].push_back(e[k]);
    refresh();
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL uf_grant got=%b exp=0100", grant); end
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          if (port_valid) nv++;
          checks++;
          if ({grant, rd_en} !== {4'b0100, 4'b0000}) begin
            failures++; $display("FAIL uf_stall%0d got=%b/%b exp=0100/0000", s, grant, rd_en);
          end
        end
        fq[2].push_back(e[3]); fq[2].push_back(e[4]);
        refresh();
      end
      tick();
      if (port_valid) nv++;
      checks++;
      if ({port_valid, port_out} !== {1'b1, e[k]}) begin
        failures++; $display("FAIL uf_byte%0d got=%b/%h exp=1/%h", k, port_valid, port_out, e[k]);
      end
    end
    checks++; if (nv != 5) begin failures++; $display("FAIL uf_total got=%0d exp=5", nv); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL uf_release got=%b exp=0000", grant); end
  endtask

  task automatic test_sw_en();
    logic [7:0] e [3];
    e = '{8'h03, 8'h01, 8'h77};
    foreach (e[k]) fq[3].push_back(e[k]);
    refresh();
    tick();
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL swen_grant got=%b exp=1000", grant); end
    sw_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({port_valid, port_out} !== {1'b1, e[k]}) begin
        failures++; $display("FAIL swen_byte%0d got=%b/%h exp=1/%h", k, port_valid, port_out, e[k]);
      end
    end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL swen_release got=%b exp=0000", grant); end
    fq[0].push_back(8'h03); fq[0].push_back(8'h00);
    refresh();
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if ({grant, rd_en} !== 8'h00) begin failures++; $display("FAIL swen_off%0d got=%b/%b exp=0000/0000", s, grant, rd_en); end
    end
    sw_en = 1'b1;
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL swen_resume got=%b exp=0001", grant); end
    tick(); tick();
    checks++; if (fq[0].size() != 0) begin failures++; $display("FAIL swen_drain got=%0d exp=0", fq[0].size()); end
  endtask

  task automatic test_reset_mid();
    fq[1].push_back(8'h03); fq[1].push_back(8'h04);
    fq[1].push_back(8'h10); fq[1].push_back(8'h20);
    fq[1].push_back(8'h30); fq[1].push_back(8'h40);
    fq[0].push_back(8'h03); fq[0].push_back(8'h00);
    fq[2].push_back(8'h03); fq[2].push_back(8'h00);
    refresh();
    tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rmid_grant got=%b exp=0010", grant); end
    tick(); tick();
    rst = 1'b1; #1;
    checks++;
    if ({grant, rd_en, port_out, port_valid} !== 17'h0) begin
      failures++; $display("FAIL rmid_clear got=%b/%b/%h/%b exp=all zero", grant, rd_en, port_out, port_valid);
    end
    tick();
    rst = 1'b0;
    checks++; if (fq[1].size() != 4) begin failures++; $display("FAIL rmid_left got=%0d exp=4", fq[1].size()); end
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rmid_regrant got=%b exp=0001", grant); end
    tick(); tick(); tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL rmid_next got=%b exp=0100", grant); end
    tick(); tick();
    fq[1].delete();
    refresh();
  endtask

  task automatic test_no_match();
    fq[0].push_back(8'h05); fq[0].push_back(8'h00);
    fq[1].push_back(8'h07);
    fq[2].push_back(8'h01);
    fq[3].push_back(8'hFF);
    refresh();
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++;
      if ({grant, rd_en} !== 8'h00) begin failures++; $display("FAIL nomatch%0d got=%b/%b exp=0000/0000", s, grant, rd_en); end
    end
    checks++;
    if (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() != 5) begin
      failures++; $display("FAIL nomatch_kept got=%0d exp=5", fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_underflow();
    test_sw_en();
    test_reset_mid();
    test_no_match();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
